// File: rtl/avalon_in_pio.sv
// Avalon-MM input port: synchronise (and optionally glitch-filter) an async bus, capture edges, count changes, raise irq.
// Latency: val at SYNC_STAGES+1 edges (+FILTER_CYCLES-1 with AVALON_IN_PIO_FILTER_EN); readdata/irq one edge later.
// Backpressure: none; writes are single-cycle and always accepted, reads have no side effects.
module avalon_in_pio #(
    parameter int WIDTH         = 10,
    parameter int SYNC_STAGES   = 2,
    parameter int EDGE_TYPE     = 0,
    parameter int FILTER_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int PW = $clog2(SYNC_STAGES + 2);

    if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || EDGE_TYPE < 0 || EDGE_TYPE > 2 ||
        FILTER_CYCLES < 2) begin : g_param_check
        $error("avalon_in_pio: illegal parameter value");
    end

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_val;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [15:0]      r_count;
    logic [PW-1:0]    r_prime_cnt;
    logic             r_primed;

    logic [WIDTH-1:0] w_sync_out;
    logic [WIDTH-1:0] w_val_next;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_w1c;
    logic             w_change;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_unused   = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    // primed rises on edge SYNC_STAGES+1, the same edge val first loads a real input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prime_cnt <= '0;
            r_primed    <= 1'b0;
        end else if (!r_primed) begin
            r_prime_cnt <= r_prime_cnt + 1'b1;
            if (r_prime_cnt == PW'(SYNC_STAGES)) r_primed <= 1'b1;
        end
    end

`ifdef AVALON_IN_PIO_FILTER_EN
    localparam int FCW = $clog2(FILTER_CYCLES);
    localparam logic [FCW-1:0] FLT_MAX = FCW'(FILTER_CYCLES - 1);

    logic [FCW-1:0] r_flt_cnt [WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) r_flt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!r_primed || (w_sync_out[i] == r_val[i]) || (r_flt_cnt[i] == FLT_MAX))
                    r_flt_cnt[i] <= '0;
                else
                    r_flt_cnt[i] <= r_flt_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        w_val_next = r_val;
        if (!r_primed) begin
            w_val_next = w_sync_out;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((w_sync_out[i] != r_val[i]) && (r_flt_cnt[i] == FLT_MAX))
                    w_val_next[i] = w_sync_out[i];
            end
        end
    end
`else
    assign w_val_next = w_sync_out;
`endif

    always_comb begin
        w_edge = '0;
        if (r_primed) begin
            case (EDGE_TYPE)
                0:       w_edge = w_val_next & ~r_val;
                1:       w_edge = ~w_val_next & r_val;
                default: w_edge = w_val_next ^ r_val;
            endcase
        end
    end

    assign w_change = r_primed && (w_val_next != r_val);
    assign w_w1c    = (write && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_val   <= '0;
            r_mask  <= '0;
            r_cap   <= '0;
            r_count <= '0;
        end else begin
            r_val <= w_val_next;
            // set wins over a same-cycle write-1-to-clear
            r_cap <= (r_cap & ~w_w1c) | w_edge;
            if (write && address == 2'd2) r_mask <= writedata[WIDTH-1:0];
            if (write && address == 2'd1)
                r_count <= w_change ? 16'd1 : 16'd0;
            else if (w_change && r_count != 16'hFFFF)
                r_count <= r_count + 16'd1;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            2'd0:    w_rdata[WIDTH-1:0] = r_val;
            2'd1:    w_rdata[15:0]      = r_count;
            2'd2:    w_rdata[WIDTH-1:0] = r_mask;
            default: w_rdata[WIDTH-1:0] = r_cap;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= w_rdata;
            irq      <= |(r_cap & r_mask);
        end
    end

endmodule

// File: tb/tb_avalon_in_pio.sv
// Directed bench for avalon_in_pio at default parameters; filter cases compile in with AVALON_IN_PIO_FILTER_EN.
module tb_avalon_in_pio;

`ifdef AVALON_IN_PIO_FILTER_EN
    localparam int F = 15;
`else
    localparam int F = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [9:0]  in_port = 10'h2A5;
    logic [31:0] readdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;
    logic [31:0] rv;

    avalon_in_pio dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    task automatic set_in(input logic [9:0] v, input int wait_cycles);
        in_port = v;
        exp_cnt++;
        tick(wait_cycles);
    endtask

    initial begin
        // reset with a non-zero input
        tick(3);
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        tick(6);
        rd(2'd0, rv); chk("prime_data", rv, 32'h2A5);
        rd(2'd3, rv); chk("prime_edgecap", rv, 32'h0);
        rd(2'd1, rv); chk("prime_count", rv, 32'h0);
        chk("prime_irq", {31'b0, irq}, 32'h0);

        wr(2'd2, 32'h1);
        rd(2'd2, rv); chk("irqmask_rb", rv, 32'h1);

        // falling edge is counted but not captured in rising mode
        set_in(10'h2A4, 30);
        rd(2'd1, rv); chk("fall_count", rv, exp_cnt);
        rd(2'd3, rv); chk("fall_nocap", rv, 32'h0);

        // rising edge: irq exactly 4+F edges after the change
        in_port = 10'h2A5;
        exp_cnt++;
        tick(3 + F);
        chk("irq_before", {31'b0, irq}, 32'h0);
        tick();
        chk("irq_rise", {31'b0, irq}, 32'h1);
        rd(2'd3, rv); chk("rise_cap", rv, 32'h1);
        rd(2'd1, rv); chk("rise_count", rv, exp_cnt);

        // write-1-to-clear: irq drops on the second edge
        wr(2'd3, 32'h1);
        chk("w1c_irq_hold", {31'b0, irq}, 32'h1);
        tick();
        chk("w1c_irq_fall", {31'b0, irq}, 32'h0);
        rd(2'd3, rv); chk("w1c_cap", rv, 32'h0);

        // set/clear collision on bit0
        set_in(10'h2A4, 30);
        set_in(10'h2A5, 30);
        set_in(10'h2A4, 30);
        chk("sticky_irq", {31'b0, irq}, 32'h1);
        in_port = 10'h2A5;
        exp_cnt++;
        tick(2 + F);
        wr(2'd3, 32'h1);
        tick();
        chk("coll_irq", {31'b0, irq}, 32'h1);
        rd(2'd3, rv); chk("coll_cap", rv, 32'h1);
        rd(2'd1, rv); chk("coll_count", rv, exp_cnt);
        wr(2'd3, 32'h1);
        tick();
        chk("coll_clear_irq", {31'b0, irq}, 32'h0);

`ifdef AVALON_IN_PIO_FILTER_EN
        // short pulse rejected, long pulse accepted
        in_port = 10'h2AD;
        tick(10);
        in_port = 10'h2A5;
        tick(30);
        rd(2'd0, rv); chk("short_data", rv, 32'h2A5);
        rd(2'd1, rv); chk("short_count", rv, exp_cnt);
        rd(2'd3, rv); chk("short_cap", rv, 32'h0);
        in_port = 10'h2AD;
        tick(20);
        in_port = 10'h2A5;
        tick(30);
        exp_cnt += 2;
        rd(2'd1, rv); chk("long_count", rv, exp_cnt);
        rd(2'd3, rv); chk("long_cap", rv, 32'h8);
        wr(2'd3, 32'h8);
`else
        // saturation
        wr(2'd1, 32'h0);
        rd(2'd1, rv); chk("count_clear", rv, 32'h0);
        for (int i = 0; i < 70000; i++) begin
            in_port = in_port ^ 10'h020;
            tick();
        end
        tick(5);
        rd(2'd1, rv); chk("count_sat", rv, 32'hFFFF);
        rd(2'd3, rv); chk("sat_cap", rv, 32'h20);
        wr(2'd3, 32'h20);
`endif

        // clear coinciding with a change loads 1
        in_port = 10'h2A4;
        tick(2 + F);
        wr(2'd1, 32'h0);
        rd(2'd1, rv); chk("clr_coll_count", rv, 32'h1);
        wr(2'd1, 32'h0);
        rd(2'd1, rv); chk("clr_count", rv, 32'h0);

        // reset mid-operation with irq high
        in_port = 10'h2A5;
        tick(30);
        chk("pre_rst_irq", {31'b0, irq}, 32'h1);
        in_port = 10'h2A4;
        tick(5);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_readdata", readdata, 32'h0);
        chk("mid_rst_irq", {31'b0, irq}, 32'h0);
        tick(3);
        in_port = 10'h2A5;
        reset_n = 1'b1;
        tick(10 + F);
        rd(2'd0, rv); chk("reprime_data", rv, 32'h2A5);
        rd(2'd3, rv); chk("reprime_cap", rv, 32'h0);
        rd(2'd1, rv); chk("reprime_count", rv, 32'h0);
        rd(2'd2, rv); chk("reprime_mask", rv, 32'h0);
        chk("reprime_irq", {31'b0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_in_pio.md
# avalon_in_pio

Parametrised Avalon-MM input port for the Nios II subsystem: the successor to the fixed 10-bit read-only input ports such as the speed reference. It synchronises an asynchronous WIDTH-bit input bus and optionally glitch-filters it. It also detects edges into a sticky capture register, counts input changes and raises a maskable level interrupt to the CPU.

## Interface
Parameters:
- WIDTH, 10, input bus width (1..32)
- SYNC_STAGES, 2, synchroniser flip-flops per bit (>=2)
- EDGE_TYPE, 0, edge capture mode: 0 rising, 1 falling, 2 any
- FILTER_CYCLES, 16, stability window in clocks (>=2); used only when the filter is compiled in

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  2  register select
- write  in  1  write strobe, single cycle
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous external input
- readdata  out  32  registered read data, reset 0
- irq  out  1  registered interrupt, active-high, reset 0

## Operation
Register map (unused upper bits read 0, writes ignored):
- Address 0, DATA (RO): qualified input value `val`, zero-extended.
- Address 1, COUNT (RW): 16-bit saturating change counter.
  - Increments by 1 in every cycle in which any bit of `val` changes, regardless of how many bits change.
  - Holds at 0xFFFF.
  - Any write clears it. A clear in the same cycle as a change loads 1.
- Address 2, IRQMASK (RW): WIDTH bits, reset 0.
- Address 3, EDGECAP (RW1C): WIDTH sticky bits, reset 0.
  - Bit i sets when `val[i]` makes a transition matching EDGE_TYPE.
  - Writing 1 clears the bit. A set and a clear in the same cycle leave the bit set (set wins).

Read and interrupt behaviour:
- readdata is reloaded from the address mux on every clock, with no read strobe and no read side effects.
- irq <= |(EDGECAP & IRQMASK), registered.

Startup priming:
- The `primed` flag is 0 after reset. It sets after SYNC_STAGES+1 clock edges and stays set.
- While unprimed, `val` loads the synchroniser output directly, bypassing the filter. EDGECAP and COUNT do not update in this phase.
- Result: a non-zero in_port at reset release creates no edge and no count.

Reset:
- Asserting reset_n at any time, including mid-filter or with irq high, asynchronously zeroes all sync stages, `val`, filter counters, COUNT, IRQMASK, EDGECAP, `primed`, readdata and irq.

## Timing
Edge numbering: in_port changes before edge 1 with setup met. Without the filter, when primed:
- Sync output changes at edge SYNC_STAGES.
- `val`, EDGECAP and COUNT update at edge SYNC_STAGES+1.
- readdata (addr 0) and irq reflect the change at edge SYNC_STAGES+2.

With the filter, each bit has a counter:
- The counter increments while sync_out[i] != val[i] and clears when they are equal.
- When the counter is FILTER_CYCLES-1 and the bit still differs, `val[i]` updates on the next edge and the counter clears.
- `val` therefore updates at edge SYNC_STAGES+FILTER_CYCLES. All later stages shift by FILTER_CYCLES-1.
- A pulse shorter than FILTER_CYCLES sync-domain cycles is rejected and produces no edge and no count.

Register writes:
- Writes take effect at the next edge.
- A read at the same address returns the new value one further edge later.

## Configuration
- AVALON_IN_PIO_FILTER_EN defined: per-bit stability filter instantiated, with $clog2(FILTER_CYCLES)-bit counters per bit.
- Not defined: the filter is omitted, `val` = sync output delayed one register, and the FILTER_CYCLES parameter is ignored.
- The register map and all other behaviour are identical in both builds.

## Test plan
- Reset release with in_port=0x2A5 and default parameters:
  - DATA reads 0x2A5.
  - EDGECAP=0, COUNT=0, irq=0.
- Rising edge with interrupt:
  - Stimulus: IRQMASK=0x001, EDGE_TYPE=0, in_port bit0 0->1.
  - Without the filter, irq rises exactly 4 edges after the input change and EDGECAP reads 0x001.
  - Write 0x001 to addr 3 -> irq falls 2 edges later.
- Set/clear collision: W1C of bit0 in the same cycle as a new bit0 rising edge -> bit0 stays set and irq stays high.
- Filter (FILTER_EN, FILTER_CYCLES=16):
  - A 10-cycle pulse on bit3 -> DATA, EDGECAP and COUNT unchanged.
  - A 20-cycle pulse -> COUNT increases by 2 and the bit3 edge is captured.
- COUNT saturation and clear:
  - 70000 toggles -> COUNT=0xFFFF.
  - A write to addr 1 coinciding with a change -> COUNT=1.
- Reset mid-operation: assert reset_n with irq=1 and the filter counter part-way -> all outputs 0 immediately; re-priming creates no spurious edge.
